datamem_pipe: RTL and testbench

DATAMEM_PIPE -- requirements
Module: datamem_pipe

---
 rtl/datamem_pkg.sv | 16 +
 rtl/datamem_lane_align.sv | 38 +++
 rtl/datamem_pipe.sv | 141 ++++++++++++++
 tb/tb_datamem_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared size encodings, word width and FSM state type for datamem_pipe
package datamem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/datamem_lane_align.sv
// rtl/datamem_lane_align.sv - write-lane merge and read extract/extend for one 32-bit storage word
module datamem_lane_align
  import datamem_pkg::*;
(
  input  logic [WORD_W-1:0] mem_word_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic              signed_i,
  output logic [WORD_W-1:0] merged_o,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] shifted;

  always_comb begin
    shifted  = mem_word_i >> {lane_i, 3'b000};
    merged_o = mem_word_i;
    rdata_o  = '0;
    case (size_i)
      SZ_BYTE: begin
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        // Half lanes are chosen by addr[1] alone; addr[0] has been resolved upstream.
        merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        merged_o = wdata_i;
        rdata_o  = mem_word_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datamem_pipe.sv
// rtl/datamem_pipe.sv - fixed-latency data memory with byte/half/word access and fault response
// Define DATAMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of forcing alignment.
module datamem_pipe
  import datamem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [2:0]  CNT_LAST   = 3'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, sgn_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [1:0]        lane_q, size_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_word, merged, rd_ext;
  logic              accept, enter_resp, misalign, req_err;
  logic [1:0]        lane_eff;

  always_comb begin
    misalign = 1'b0;
    lane_eff = req_addr[1:0];
`ifdef DATAMEM_ALIGN_CHECK_EN
    misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == SZ_HALF) lane_eff = {req_addr[1], 1'b0};
    else if (req_size == SZ_WORD) lane_eff = 2'b00;
`endif
    req_err = (req_addr >= ADDR_LIMIT) || (req_size == 2'd3) || misalign;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        req_ready = 1'b1;
        state_d   = req_valid ? WAIT : IDLE;
        cnt_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_q == WAIT) && (cnt_q == CNT_LAST);
  assign mem_word   = mem_q[idx_q];

  datamem_lane_align u_align (
    .mem_word_i (mem_word),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .lane_i     (lane_q),
    .signed_i   (sgn_q),
    .merged_o   (merged),
    .rdata_o    (rd_ext)
  );

  // Read data is sampled on the same edge a write would commit, so back-to-back
  // write-then-read to one word always sees the committed value.
  assign rsp_rdata_d = (enter_resp && !we_q && !err_q) ? rd_ext : '0;
  assign rsp_err_d   = enter_resp && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= SZ_WORD;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        err_q   <= req_err;
        idx_q   <= req_addr[AW+1:2];
        lane_q  <= lane_eff;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (enter_resp && we_q && !err_q) mem_q[idx_q] <= merged;
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_datamem_pipe.sv
// tb/tb_datamem_pipe.sv - scoreboard bench for datamem_pipe (DEPTH=1024, LATENCY=2)
module tb_datamem_pipe;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  datamem_pipe #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rd);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.er});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_rdata", rsp_rdata, 32'd0);
        chk("idle_err", {31'd0, rsp_err}, 32'd0);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_er, input bit hold, input bit want_rsp, output int waits);
    exp_t x;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = sz; req_signed = sgn; req_wdata = wd;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
    end else begin
      if (want_rsp) begin
        x.rd = exp_rd; x.er = exp_er; x.cyc = cyc + 1 + LAT;
        sb.push_back(x);
      end
      @(posedge clk);
      if (!hold) #1 req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  int w;
  logic [31:0] exp_21;
  logic        err_21;

  initial begin
    @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0, 0, 1, w);
    issue(0, 32'h10, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0, 0, 1, w);
    issue(1, 32'h13, 2'd0, 0, 32'h80, 32'h0, 0, 0, 1, w);
    issue(0, 32'h13, 2'd0, 1, 32'h0, 32'hFFFFFF80, 0, 0, 1, w);
    issue(0, 32'h13, 2'd0, 0, 32'h0, 32'h00000080, 0, 0, 1, w);
    issue(0, 32'h10, 2'd2, 0, 32'h0, 32'h80ADBEEF, 0, 0, 1, w);
    issue(0, 32'h12, 2'd1, 1, 32'h0, 32'hFFFF80AD, 0, 0, 1, w);
    issue(0, 32'h10, 2'd1, 0, 32'h0, 32'h0000BEEF, 0, 0, 1, w);

    issue(1, 32'h0, 2'd2, 0, 32'hA5A5A5A5, 32'h0, 0, 0, 1, w);
    issue(0, 32'h1000, 2'd2, 0, 32'h0, 32'h0, 1, 0, 1, w);
    issue(1, 32'h1000, 2'd2, 0, 32'h11111111, 32'h0, 1, 0, 1, w);
    issue(0, 32'h0, 2'd2, 0, 32'h0, 32'hA5A5A5A5, 0, 0, 1, w);
    issue(0, 32'h10, 2'd3, 0, 32'h0, 32'h0, 1, 0, 1, w);

    issue(1, 32'h14, 2'd2, 0, 32'h0, 32'h0, 0, 0, 1, w);
    issue(1, 32'h16, 2'd1, 0, 32'hFFFFABCD, 32'h0, 0, 0, 1, w);

    // held-valid burst: write-then-read hazard plus four back-to-back reads
    issue(1, 32'h20, 2'd2, 0, 32'hCAFEF00D, 32'h0, 0, 1, 1, w);
    issue(0, 32'h20, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0, 1, 1, w);
    chk("hazard_ready_low", w, LAT);
    issue(0, 32'h10, 2'd2, 0, 32'h0, 32'h80ADBEEF, 0, 1, 1, w);
    chk("b2b_ready_low_1", w, LAT);
    issue(0, 32'h0, 2'd2, 0, 32'h0, 32'hA5A5A5A5, 0, 1, 1, w);
    chk("b2b_ready_low_2", w, LAT);
    issue(0, 32'h14, 2'd2, 0, 32'h0, 32'hABCD0000, 0, 1, 1, w);
    chk("b2b_ready_low_3", w, LAT);
    issue(0, 32'h13, 2'd0, 1, 32'h0, 32'hFFFFFF80, 0, 0, 1, w);
    chk("b2b_ready_low_4", w, LAT);

    // reset one cycle after accepting a write: no response, no commit
    issue(1, 32'h20, 2'd2, 0, 32'h12345678, 32'h0, 0, 0, 0, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    chk("midrst_err", {31'd0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(0, 32'h20, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0, 0, 1, w);

`ifdef DATAMEM_ALIGN_CHECK_EN
    exp_21 = 32'h0; err_21 = 1'b1;
`else
    exp_21 = 32'h0000F00D; err_21 = 1'b0;
`endif
    issue(0, 32'h21, 2'd1, 0, 32'h0, exp_21, err_21, 0, 1, w);

    repeat (20) begin
      if (sb.size() != 0) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
